riscv_op2_fwd_stage: RTL and testbench
======================================

RISCV_OP2_FWD_STAGE -- requirements
Module: riscv_op2_fwd_stage

Interface
REQ-001 Parameter WORD_LENGTH, default 32, SHALL set the datapath width.
REQ-002 Parameter REG_ADDR_W, default 5, SHALL set the register-address width.
REQ-003 Parameter CNT_W, default 16, SHALL set the stall-counter width.
REQ-004 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: reset, synchronous and active-high.
REQ-006 Port in_valid, input, 1: decode-side operand request valid.
REQ-007 Port in_ready, output, 1: stage accepts the request this cycle.
REQ-008 Port op2_sel, input, OP2_SEL: operand-2 source select (OP2_RS2, OP2_IMI, OP2_IMS, OP2_IMJ, OP2_IMU).
REQ-009 Port rs2_addr, input, REG_ADDR_W: rs2 register index.
REQ-010 Port rs2_data, input, WORD_LENGTH: register-file rs2 read data.
REQ-011 Ports imm_i_sext, imm_s_sext, imm_j_sext, imm_u_sext, input, WORD_LENGTH each: sign-extended immediates.
REQ-012 Ports ex_wen (1), ex_is_load (1), ex_rd (REG_ADDR_W), ex_data (WORD_LENGTH), input: EX-stage writeback info.
REQ-013 Ports mem_wen (1), mem_rd (REG_ADDR_W), mem_data (WORD_LENGTH), input: MEM-stage writeback info.
REQ-014 Port flush, input, 1: discard held and incoming operand.
REQ-015 Port out_valid, output, 1: registered operand valid.
REQ-016 Port out_ready, input, 1: downstream consumes operand.
REQ-017 Port dout, output, WORD_LENGTH: registered operand 2.
REQ-018 Port fwd_src, output, 2: registered source tag; 0 regfile/immediate, 1 EX, 2 MEM.
REQ-019 Port stall_cnt, output, CNT_W: load-use stall cycle count.

Function
REQ-020 ex_hit SHALL be ex_wen && ex_rd==rs2_addr && rs2_addr!=0; mem_hit SHALL be mem_wen && mem_rd==rs2_addr && rs2_addr!=0.
REQ-021 Forwarded rs2 SHALL be ex_data if ex_hit && !ex_is_load, else mem_data if mem_hit, else rs2_data; EX priority over MEM.
REQ-022 hazard SHALL be in_valid && op2_sel==OP2_RS2 && ex_hit && ex_is_load.
REQ-023 Selected value SHALL be forwarded rs2 for OP2_RS2, imm_i/s/j/u_sext for OP2_IMI/IMS/IMJ/IMU, and 0 for any other encoding.
REQ-024 Forwarding SHALL affect only OP2_RS2; immediate selects report fwd_src 0.
REQ-025 in_ready SHALL be combinational: (!out_valid || out_ready) && !hazard && !flush.
REQ-026 Capture SHALL occur when in_valid && in_ready; dout and fwd_src load next edge; latency one cycle.
REQ-027 out_valid next SHALL be: 0 if flush; else 1 if capture; else 0 if out_ready; else hold.
REQ-028 While out_valid && !out_ready, dout and fwd_src SHALL hold stable.
REQ-029 Flush SHALL take priority over capture and over hazard; dout/fwd_src need not clear on flush.
REQ-030 stall_cnt SHALL increment by 1 each cycle hazard is 1 and saturate at 2^CNT_W-1.
REQ-031 Simultaneous consume and capture (out_valid && out_ready && in_valid && in_ready) SHALL keep out_valid 1 with new data; no bubble.

Reset
REQ-032 On rst at a clock edge, out_valid, dout, fwd_src and stall_cnt SHALL be 0; rst overrides flush and capture.
REQ-033 Reset asserted mid-transfer SHALL drop the held operand; in_ready SHALL be 1 in the first cycle after reset release if no hazard.

Verification
REQ-034 OP2_IMI, imm_i_sext=0xFFFFF800, in_valid=1, out_ready=1 -> next cycle out_valid=1, dout=0xFFFFF800, fwd_src=0.
REQ-035 OP2_RS2, rs2_addr=5, ex_wen=1, ex_rd=5, ex_data=0x11, mem_wen=1, mem_rd=5, mem_data=0x22 -> dout=0x11, fwd_src=1; with rs2_addr=0 -> dout=rs2_data, fwd_src=0.
REQ-036 OP2_RS2, rs2_addr=7, ex_is_load=1, ex_wen=1, ex_rd=7 for 2 cycles, then load advances to MEM (mem_rd=7, mem_data=0xABCD) -> in_ready=0 both cycles, stall_cnt=2, then dout=0xABCD, fwd_src=2.
REQ-037 Capture 0xA, hold out_ready=0 3 cycles with new in_valid -> dout stays 0xA, in_ready=0; out_ready=1 -> new operand captured with no bubble.
REQ-038 out_valid=1, assert flush with in_valid=1 -> next cycle out_valid=0, no capture; rst during held operand -> all outputs 0.
REQ-039 CNT_W=2, hazard held 5 cycles -> stall_cnt reaches 3 and holds.

Source files
------------

// File: rtl/riscv_op2_fwd_stage.sv
`default_nettype none
// ============================================================================
// Module      : riscv_op2_fwd_stage
// Description : Operand-2 select and forwarding stage. Resolves rs2 against
//               the EX and MEM writeback ports, selects between forwarded rs2
//               and the sign-extended immediates, detects load-use hazards,
//               and registers the operand behind a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_op2_fwd_stage #(
    parameter int WORD_LENGTH = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int CNT_W       = 16,
    parameter int OP2_SEL_W   = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    // Decode-side request
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [OP2_SEL_W-1:0]   op2_sel,
    input  logic [REG_ADDR_W-1:0]  rs2_addr,
    input  logic [WORD_LENGTH-1:0] rs2_data,
    input  logic [WORD_LENGTH-1:0] imm_i_sext,
    input  logic [WORD_LENGTH-1:0] imm_s_sext,
    input  logic [WORD_LENGTH-1:0] imm_j_sext,
    input  logic [WORD_LENGTH-1:0] imm_u_sext,
    // EX-stage writeback
    input  logic                   ex_wen,
    input  logic                   ex_is_load,
    input  logic [REG_ADDR_W-1:0]  ex_rd,
    input  logic [WORD_LENGTH-1:0] ex_data,
    // MEM-stage writeback
    input  logic                   mem_wen,
    input  logic [REG_ADDR_W-1:0]  mem_rd,
    input  logic [WORD_LENGTH-1:0] mem_data,
    // Control and registered output
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORD_LENGTH-1:0] dout,
    output logic [1:0]             fwd_src,
    output logic [CNT_W-1:0]       stall_cnt
);

    // Operand-2 source select encodings
    localparam logic [OP2_SEL_W-1:0] c_OP2_RS2 = OP2_SEL_W'(0);
    localparam logic [OP2_SEL_W-1:0] c_OP2_IMI = OP2_SEL_W'(1);
    localparam logic [OP2_SEL_W-1:0] c_OP2_IMS = OP2_SEL_W'(2);
    localparam logic [OP2_SEL_W-1:0] c_OP2_IMJ = OP2_SEL_W'(3);
    localparam logic [OP2_SEL_W-1:0] c_OP2_IMU = OP2_SEL_W'(4);

    // Source tags reported on fwd_src
    localparam logic [1:0] c_SRC_RF  = 2'd0;
    localparam logic [1:0] c_SRC_EX  = 2'd1;
    localparam logic [1:0] c_SRC_MEM = 2'd2;

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic                   w_ex_hit;
    logic                   w_mem_hit;
    logic                   w_hazard;
    logic                   w_capture;
    logic [WORD_LENGTH-1:0] w_fwd_rs2;
    logic [1:0]             w_fwd_tag;
    logic [WORD_LENGTH-1:0] w_sel_val;
    logic [1:0]             w_sel_tag;

    logic                   r_out_valid;
    logic [WORD_LENGTH-1:0] r_dout;
    logic [1:0]             r_fwd_src;
    logic [CNT_W-1:0]       r_stall_cnt;

    // x0 is hardwired to zero, so a write to it never produces a match.
    assign w_ex_hit  = ex_wen  && (ex_rd  == rs2_addr) && (rs2_addr != '0);
    assign w_mem_hit = mem_wen && (mem_rd == rs2_addr) && (rs2_addr != '0);

    // A load in EX has no data yet; the consumer must wait for it to reach MEM.
    assign w_hazard  = in_valid && (op2_sel == c_OP2_RS2) && w_ex_hit && ex_is_load;

    assign in_ready  = (!r_out_valid || out_ready) && !w_hazard && !flush;
    assign w_capture = in_valid && in_ready;

    // Resolve rs2 with the youngest producer (EX) taking priority over MEM.
    always_comb begin
        w_fwd_rs2 = rs2_data;
        w_fwd_tag = c_SRC_RF;
        if (w_ex_hit && !ex_is_load) begin
            w_fwd_rs2 = ex_data;
            w_fwd_tag = c_SRC_EX;
        end else if (w_mem_hit) begin
            w_fwd_rs2 = mem_data;
            w_fwd_tag = c_SRC_MEM;
        end
    end

    // Operand-2 mux; immediates never carry a forwarding tag.
    always_comb begin
        w_sel_val = '0;
        w_sel_tag = c_SRC_RF;
        case (op2_sel)
            c_OP2_RS2: begin
                w_sel_val = w_fwd_rs2;
                w_sel_tag = w_fwd_tag;
            end
            c_OP2_IMI: w_sel_val = imm_i_sext;
            c_OP2_IMS: w_sel_val = imm_s_sext;
            c_OP2_IMJ: w_sel_val = imm_j_sext;
            c_OP2_IMU: w_sel_val = imm_u_sext;
            default:   w_sel_val = '0;
        endcase
    end

    // Output register with valid/ready handshake; flush beats capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_dout      <= '0;
            r_fwd_src   <= c_SRC_RF;
        end else begin
            if (flush) begin
                r_out_valid <= 1'b0;
            end else if (w_capture) begin
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_capture) begin
                r_dout    <= w_sel_val;
                r_fwd_src <= w_sel_tag;
            end
        end
    end

    // Saturating count of load-use stall cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_hazard && (r_stall_cnt != c_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign out_valid = r_out_valid;
    assign dout      = r_dout;
    assign fwd_src   = r_fwd_src;
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_riscv_op2_fwd_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_op2_fwd_stage
// Description : Self-checking bench for riscv_op2_fwd_stage. A behavioural
//               model tracks the expected operand register and stall count;
//               directed scenarios are followed by randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_op2_fwd_stage;

    localparam int W = 32;
    localparam int A = 5;

    localparam logic [2:0] SEL_RS2 = 3'd0;
    localparam logic [2:0] SEL_IMI = 3'd1;
    localparam logic [2:0] SEL_IMS = 3'd2;
    localparam logic [2:0] SEL_IMJ = 3'd3;
    localparam logic [2:0] SEL_IMU = 3'd4;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready, in_ready2;
    logic [2:0]   op2_sel;
    logic [A-1:0] rs2_addr;
    logic [W-1:0] rs2_data, imm_i_sext, imm_s_sext, imm_j_sext, imm_u_sext;
    logic         ex_wen, ex_is_load;
    logic [A-1:0] ex_rd;
    logic [W-1:0] ex_data;
    logic         mem_wen;
    logic [A-1:0] mem_rd;
    logic [W-1:0] mem_data;
    logic         flush;
    logic         out_valid, out_valid2;
    logic         out_ready;
    logic [W-1:0] dout, dout2;
    logic [1:0]   fwd_src, fwd_src2;
    logic [15:0]  stall_cnt;
    logic [1:0]   stall_cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic         m_valid;
    logic [W-1:0] m_dout;
    logic [1:0]   m_src;
    int           m_cnt;
    int           m_cnt2;

    riscv_op2_fwd_stage #(.WORD_LENGTH(W), .REG_ADDR_W(A), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op2_sel(op2_sel), .rs2_addr(rs2_addr), .rs2_data(rs2_data),
        .imm_i_sext(imm_i_sext), .imm_s_sext(imm_s_sext),
        .imm_j_sext(imm_j_sext), .imm_u_sext(imm_u_sext),
        .ex_wen(ex_wen), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_data(ex_data),
        .mem_wen(mem_wen), .mem_rd(mem_rd), .mem_data(mem_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .dout(dout), .fwd_src(fwd_src), .stall_cnt(stall_cnt)
    );

    // Narrow-counter instance sharing the same stimulus, for saturation.
    riscv_op2_fwd_stage #(.WORD_LENGTH(W), .REG_ADDR_W(A), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .op2_sel(op2_sel), .rs2_addr(rs2_addr), .rs2_data(rs2_data),
        .imm_i_sext(imm_i_sext), .imm_s_sext(imm_s_sext),
        .imm_j_sext(imm_j_sext), .imm_u_sext(imm_u_sext),
        .ex_wen(ex_wen), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_data(ex_data),
        .mem_wen(mem_wen), .mem_rd(mem_rd), .mem_data(mem_data),
        .flush(flush), .out_valid(out_valid2), .out_ready(out_ready),
        .dout(dout2), .fwd_src(fwd_src2), .stall_cnt(stall_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic ref_hazard();
        return in_valid && op2_sel == SEL_RS2 && ex_wen && ex_is_load &&
               ex_rd == rs2_addr && rs2_addr != 0;
    endfunction

    function automatic logic ref_ready();
        return (!m_valid || out_ready) && !ref_hazard() && !flush;
    endfunction

    function automatic void ref_operand(output logic [W-1:0] v, output logic [1:0] s);
        v = 0;
        s = 0;
        if (op2_sel == SEL_RS2) begin
            if (rs2_addr != 0 && ex_wen && ex_rd == rs2_addr && !ex_is_load) begin
                v = ex_data; s = 1;
            end else if (rs2_addr != 0 && mem_wen && mem_rd == rs2_addr) begin
                v = mem_data; s = 2;
            end else begin
                v = rs2_data;
            end
        end else if (op2_sel == SEL_IMI) v = imm_i_sext;
        else if (op2_sel == SEL_IMS) v = imm_s_sext;
        else if (op2_sel == SEL_IMJ) v = imm_j_sext;
        else if (op2_sel == SEL_IMU) v = imm_u_sext;
    endfunction

    // Advance one clock, updating the model from the pre-edge inputs.
    task automatic tick();
        logic [W-1:0] v;
        logic [1:0]   s;
        logic         hz, cap;
        ref_operand(v, s);
        hz  = ref_hazard();
        cap = in_valid && ref_ready();
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_dout = 0; m_src = 0; m_cnt = 0; m_cnt2 = 0;
        end else begin
            if (hz) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
            if (flush) m_valid = 0;
            else if (cap) begin m_valid = 1; m_dout = v; m_src = s; end
            else if (out_ready) m_valid = 0;
        end
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; op2_sel = SEL_RS2; rs2_addr = 0; rs2_data = 0;
        imm_i_sext = 0; imm_s_sext = 0; imm_j_sext = 0; imm_u_sext = 0;
        ex_wen = 0; ex_is_load = 0; ex_rd = 0; ex_data = 0;
        mem_wen = 0; mem_rd = 0; mem_data = 0; flush = 0; out_ready = 1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        in_valid = 1; op2_sel = SEL_IMU; imm_u_sext = 32'hDEAD0000; flush = 1;
        rst = 1;
        tick();
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
        n_checks++; if (dout !== 32'h0) begin n_fail++; $display("FAIL reset_dout: got %0h want 0", dout); end
        n_checks++; if (fwd_src !== 2'd0) begin n_fail++; $display("FAIL reset_src: got %0d want 0", fwd_src); end
        n_checks++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
        rst = 0; flush = 0; in_valid = 0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b want 1", in_ready); end
    endtask

    task automatic test_imm_i();
        idle_inputs();
        in_valid = 1; op2_sel = SEL_IMI; imm_i_sext = 32'hFFFFF800; out_ready = 1;
        tick();
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL imm_valid: got %0b want 1", out_valid); end
        n_checks++; if (dout !== 32'hFFFFF800) begin n_fail++; $display("FAIL imm_dout: got %0h want fffff800", dout); end
        n_checks++; if (fwd_src !== 2'd0) begin n_fail++; $display("FAIL imm_src: got %0d want 0", fwd_src); end
    endtask

    task automatic test_forward_priority();
        idle_inputs();
        in_valid = 1; op2_sel = SEL_RS2; rs2_addr = 5; rs2_data = 32'h3333;
        ex_wen = 1; ex_rd = 5; ex_data = 32'h11; mem_wen = 1; mem_rd = 5; mem_data = 32'h22;
        tick();
        n_checks++; if (dout !== 32'h11 || fwd_src !== 2'd1) begin n_fail++; $display("FAIL fwd_ex: got %0h/%0d want 11/1", dout, fwd_src); end
        ex_wen = 0;
        tick();
        n_checks++; if (dout !== 32'h22 || fwd_src !== 2'd2) begin n_fail++; $display("FAIL fwd_mem: got %0h/%0d want 22/2", dout, fwd_src); end
        ex_wen = 1; ex_rd = 0; mem_rd = 0; rs2_addr = 0;
        tick();
        n_checks++; if (dout !== 32'h3333 || fwd_src !== 2'd0) begin n_fail++; $display("FAIL fwd_x0: got %0h/%0d want 3333/0", dout, fwd_src); end
        op2_sel = SEL_IMS; imm_s_sext = 32'h44; rs2_addr = 5; ex_rd = 5;
        tick();
        n_checks++; if (dout !== 32'h44 || fwd_src !== 2'd0) begin n_fail++; $display("FAIL imm_s_nofwd: got %0h/%0d want 44/0", dout, fwd_src); end
        op2_sel = 3'd6;
        tick();
        n_checks++; if (dout !== 32'h0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bad_sel: got %0h/%0b want 0/1", dout, out_valid); end
    endtask

    task automatic test_load_use();
        do_reset();
        in_valid = 1; op2_sel = SEL_RS2; rs2_addr = 7; rs2_data = 32'h5555;
        ex_wen = 1; ex_is_load = 1; ex_rd = 7; ex_data = 32'h9999;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL load_use_ready: got %0b want 0 (cycle %0d)", in_ready, i); end
            tick();
        end
        n_checks++; if (stall_cnt !== 16'd2) begin n_fail++; $display("FAIL load_use_cnt: got %0d want 2", stall_cnt); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL load_use_novalid: got %0b want 0", out_valid); end
        ex_wen = 0; ex_is_load = 0; mem_wen = 1; mem_rd = 7; mem_data = 32'hABCD;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL load_use_release: got %0b want 1", in_ready); end
        tick();
        n_checks++; if (dout !== 32'hABCD || fwd_src !== 2'd2) begin n_fail++; $display("FAIL load_use_data: got %0h/%0d want abcd/2", dout, fwd_src); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        in_valid = 1; op2_sel = SEL_IMI; imm_i_sext = 32'hA; out_ready = 1;
        tick();
        imm_i_sext = 32'hB; out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready: got %0b want 0 (cycle %0d)", in_ready, i); end
            tick();
            n_checks++; if (dout !== 32'hA || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold: got %0h/%0b want a/1", dout, out_valid); end
        end
        out_ready = 1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got %0b want 1", in_ready); end
        tick();
        n_checks++; if (dout !== 32'hB || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_nobubble: got %0h/%0b want b/1", dout, out_valid); end
    endtask

    task automatic test_flush();
        // Operand B is still held from the previous scenario.
        out_ready = 0; flush = 1; in_valid = 1; imm_i_sext = 32'hC;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %0b want 0", in_ready); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %0b want 0", out_valid); end
        flush = 0; imm_i_sext = 32'hD;
        tick();
        n_checks++; if (dout !== 32'hD || out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_recap: got %0h/%0b want d/1", dout, out_valid); end
        rst = 1;
        tick();
        rst = 0;
        n_checks++; if (out_valid !== 1'b0 || dout !== 32'h0 || fwd_src !== 2'd0 || stall_cnt !== 16'd0) begin
            n_fail++; $display("FAIL mid_reset: got %0b/%0h/%0d/%0d want 0/0/0/0", out_valid, dout, fwd_src, stall_cnt);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        in_valid = 1; op2_sel = SEL_RS2; rs2_addr = 3; ex_wen = 1; ex_is_load = 1; ex_rd = 3;
        for (int i = 1; i <= 5; i++) begin
            tick();
            n_checks++; if (stall_cnt2 !== 2'((i > 3) ? 3 : i)) begin n_fail++; $display("FAIL sat_cnt2: got %0d want %0d", stall_cnt2, (i > 3) ? 3 : i); end
            n_checks++; if (stall_cnt !== 16'(i)) begin n_fail++; $display("FAIL sat_cnt16: got %0d want %0d", stall_cnt, i); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 99) == 0);
            in_valid   = $urandom_range(0, 3) != 0;
            op2_sel    = 3'($urandom_range(0, 6));
            rs2_addr   = 5'($urandom_range(0, 3));
            rs2_data   = $urandom;
            imm_i_sext = $urandom; imm_s_sext = $urandom;
            imm_j_sext = $urandom; imm_u_sext = $urandom;
            ex_wen     = $urandom_range(0, 1);
            ex_is_load = ($urandom_range(0, 3) == 0);
            ex_rd      = 5'($urandom_range(0, 3));
            ex_data    = $urandom;
            mem_wen    = $urandom_range(0, 1);
            mem_rd     = 5'($urandom_range(0, 3));
            mem_data   = $urandom;
            flush      = ($urandom_range(0, 15) == 0);
            out_ready  = $urandom_range(0, 2) != 0;
            #1;
            n_checks++; if (in_ready !== ref_ready()) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %0b want %0b", i, in_ready, ref_ready()); end
            tick();
            n_checks++; if (out_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %0b want %0b", i, out_valid, m_valid); end
            if (m_valid) begin
                n_checks++; if (dout !== m_dout || fwd_src !== m_src) begin
                    n_fail++; $display("FAIL rnd_data[%0d]: got %0h/%0d want %0h/%0d", i, dout, fwd_src, m_dout, m_src);
                end
            end
            n_checks++; if (stall_cnt !== 16'(m_cnt) || stall_cnt2 !== 2'(m_cnt2)) begin
                n_fail++; $display("FAIL rnd_cnt[%0d]: got %0d/%0d want %0d/%0d", i, stall_cnt, stall_cnt2, m_cnt, m_cnt2);
            end
        end
        rst = 0;
    endtask

    initial begin
        m_valid = 0; m_dout = 0; m_src = 0; m_cnt = 0; m_cnt2 = 0;
        rst = 1;
        idle_inputs();
        test_reset();
        test_imm_i();
        test_forward_priority();
        test_load_use();
        test_back_to_back();
        test_flush();
        test_saturate();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
